// File: rtl/mult_digito_serie.sv
// Digit-serial x parallel unsigned multiplier.
// Operand A arrives one size-bit digit per accepted cycle, least-significant
// digit first, straight from the upstream digit shifter. Operand B is latched
// on start. Each accepted digit adds its partial product at bit offset
// size*k, and the full-width product is published with a one-cycle done.
module mult_digito_serie #(
    parameter int size = 8,
    parameter int ndig = 4,
    parameter int wb   = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     start,
    input  logic [wb-1:0]            operando_b,
    input  logic [size-1:0]          entrada_serie,
    input  logic                     digito_valid,
    output logic                     enable_shift,
    output logic                     busy,
    output logic                     done,
    output logic [size*ndig+wb-1:0]  producto
);

    localparam int PW = size*ndig + wb;
    localparam int CW = (ndig > 1) ? $clog2(ndig) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [PW-1:0]       acc;
    logic [PW-1:0]       acc_next;
    logic [size+wb-1:0]  pp;
    logic [CW-1:0]       cnt;
    logic [wb-1:0]       b_lat;
    logic                accept;
    logic                last_digit;

    // Partial product of the current digit, placed at its digit offset.
    always_comb begin
        pp         = {{wb{1'b0}}, entrada_serie} * {{size{1'b0}}, b_lat};
        acc_next   = acc + (PW'(pp) << (size * int'(cnt)));
        accept     = (state == RUN) && digito_valid;
        last_digit = (cnt == CW'(ndig - 1));
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; clear returns to IDLE from anywhere without a done.
    always_comb begin
        state_next = state;
        if (!clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_next = RUN;
                RUN:     if (accept && last_digit) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath: latch B, accumulate partial products, publish the product.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            cnt      <= '0;
            b_lat    <= '0;
            producto <= '0;
        end else if (!clear) begin
            acc      <= '0;
            cnt      <= '0;
            b_lat    <= '0;
            producto <= '0;
        end else begin
            if (state == IDLE && start) begin
                b_lat <= operando_b;
                acc   <= '0;
                cnt   <= '0;
            end else if (accept) begin
                acc <= acc_next;
                cnt <= cnt + CW'(1);
                if (last_digit) producto <= acc_next;
            end
        end
    end

    // Status outputs decoded from the state; the shifter advances per accepted digit.
    always_comb begin
        enable_shift = accept;
        busy         = (state != IDLE);
        done         = (state == DONE);
    end

endmodule

// File: tb/tb_mult_digito_serie.sv
// Bench for mult_digito_serie: directed runs against a product-level model.
module tb_mult_digito_serie;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        start;
    logic [31:0] operando_b;
    logic [7:0]  entrada;
    logic        valid;
    logic        enable_shift;
    logic        busy;
    logic        done;
    logic [63:0] producto;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int en_cnt = 0;
    int done_cnt = 0;

    mult_digito_serie #(.size(8), .ndig(4), .wb(32)) dut (
        .clock         (clk),
        .reset         (rst_n),
        .clear         (clear),
        .start         (start),
        .operando_b    (operando_b),
        .entrada_serie (entrada),
        .digito_valid  (valid),
        .enable_shift  (enable_shift),
        .busy          (busy),
        .done          (done),
        .producto      (producto)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: collect digits of A, then multiply whole operands.
    int          m_st;    // 0 idle, 1 collecting digits, 2 result cycle
    int          m_cnt;
    logic [63:0] m_a;
    logic [63:0] m_b;
    logic [63:0] m_prod;

    always @(posedge clk or negedge rst_n) begin
        logic [63:0] a_new;
        if (!rst_n || !clear) begin
            m_st   <= 0;
            m_cnt  <= 0;
            m_a    <= '0;
            m_b    <= '0;
            m_prod <= '0;
        end else begin
            case (m_st)
                0: if (start) begin
                    m_b   <= {32'd0, operando_b};
                    m_a   <= '0;
                    m_cnt <= 0;
                    m_st  <= 1;
                end
                1: if (valid) begin
                    a_new = m_a | ({56'd0, entrada} << (8 * m_cnt));
                    m_a   <= a_new;
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == 3) begin
                        m_prod <= a_new * m_b;
                        m_st   <= 2;
                    end
                end
                default: m_st <= 0;
            endcase
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (enable_shift) en_cnt++;
        if (done) done_cnt++;
        check("cyc_busy", {63'd0, busy}, {63'd0, m_st != 0});
        check("cyc_done", {63'd0, done}, {63'd0, m_st == 2});
        check("cyc_enable_shift", {63'd0, enable_shift}, {63'd0, (m_st == 1) && valid});
        check("cyc_producto", producto, m_prod);
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One full multiplication; optional stall after digit 0 and optional
    // start/operand pokes while busy.
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                            input int stall, input bit poke,
                            input logic [63:0] exp, input string tag);
        int t0;
        en_cnt   = 0;
        done_cnt = 0;
        start      = 1;
        operando_b = b;
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                repeat (stall) begin
                    valid = 0;
                    @(posedge clk);
                    #1;
                end
            end
            if (poke && k == 2) begin
                start      = 1;
                operando_b = ~b;
            end
            valid   = 1;
            entrada = a[8*k +: 8];
            @(posedge clk);
            #1;
        end
        valid = 0;
        if (poke) operando_b = 32'h1234_5678;
        check({tag, "_done_high"}, {63'd0, done}, 64'd1);
        check({tag, "_producto"}, producto, exp);
        check({tag, "_latency"}, 64'(cyc - t0), 64'(4 + stall));
        @(posedge clk);
        #1;
        start = 0;
        check({tag, "_done_low"}, {63'd0, done}, 64'd0);
        check({tag, "_busy_low"}, {63'd0, busy}, 64'd0);
        check({tag, "_enable_count"}, 64'(en_cnt), 64'd4);
        idle_cycles(2);
        check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        check({tag, "_producto_held"}, producto, exp);
    endtask

    initial begin
        rst_n      = 0;
        clear      = 1;
        start      = 0;
        valid      = 0;
        entrada    = '0;
        operando_b = '0;
        #1;
        check("reset_producto", producto, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_enable", {63'd0, enable_shift}, 64'd0);
        idle_cycles(2);
        #2 rst_n = 1;
        idle_cycles(2);

        run_mult(32'h0102_0304, 32'h0000_0010, 0, 0, 64'h0000_0000_1020_3040, "basic");
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 64'hFFFF_FFFE_0000_0001, "max");
        run_mult(32'h0000_0102, 32'h0000_0003, 3, 0, 64'h0000_0000_0000_0306, "stall");
        run_mult(32'h0000_0102, 32'h0000_0003, 0, 1, 64'h0000_0000_0000_0306, "poke");

        // Clear after two digits aborts the run and zeroes the product.
        done_cnt   = 0;
        start      = 1;
        operando_b = 32'h9;
        @(posedge clk);
        #1;
        start = 0;
        for (int k = 0; k < 2; k++) begin
            valid   = 1;
            entrada = 8'h11;
            @(posedge clk);
            #1;
        end
        clear = 0;
        start = 1;
        @(posedge clk);
        #1;
        clear = 1;
        start = 0;
        valid = 0;
        check("clear_busy", {63'd0, busy}, 64'd0);
        check("clear_producto", producto, 64'd0);
        idle_cycles(3);
        check("clear_no_done", 64'(done_cnt), 64'd0);
        run_mult(32'h0000_0005, 32'h0000_0007, 0, 0, 64'h23, "after_clear");

        // Asynchronous reset between edges in the middle of a run.
        done_cnt   = 0;
        start      = 1;
        operando_b = 32'h5;
        @(posedge clk);
        #1;
        start = 0;
        for (int k = 0; k < 2; k++) begin
            valid   = 1;
            entrada = 8'h22;
            @(posedge clk);
            #1;
        end
        #2 rst_n = 0;
        #1;
        check("areset_enable", {63'd0, enable_shift}, 64'd0);
        check("areset_busy", {63'd0, busy}, 64'd0);
        check("areset_done", {63'd0, done}, 64'd0);
        check("areset_producto", producto, 64'd0);
        @(posedge clk);
        #2 rst_n = 1;
        idle_cycles(4);
        valid = 0;
        check("areset_stays_idle", {63'd0, busy}, 64'd0);
        check("areset_no_done", 64'(done_cnt), 64'd0);
        run_mult(32'h0000_0005, 32'h0000_0007, 0, 0, 64'h23, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
